// File: rtl/uart_frame_rx_if.sv
// rtl/uart_frame_rx_if.sv - byte-in / word-out bundle between uart core, frame receiver and board logic
// Ports (signals):
//   read_done   byte-received flag from the uart core (rising edge = new byte)
//   read_data   received byte, stable when read_done rises
//   data        last good word (8*WORD_BYTES bits)
//   data_valid  one-cycle strobe, data just updated
//   frame_err   one-cycle strobe, bad checksum or timeout
//   busy        frame in progress (PAYLOAD or CHECK)
//   sta         state code for a 7-seg digit
// Modports: master = byte source / word consumer side, slave = the frame receiver.
interface uart_frame_rx_if #(
  parameter int WORD_BYTES = 4
) ();
  logic                      read_done;
  logic [7:0]                read_data;
  logic [8*WORD_BYTES-1:0]   data;
  logic                      data_valid;
  logic                      frame_err;
  logic                      busy;
  logic [3:0]                sta;

  modport master (
    output read_done, read_data,
    input  data, data_valid, frame_err, busy, sta
  );

  modport slave (
    input  read_done, read_data,
    output data, data_valid, frame_err, busy, sta
  );
endinterface

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - reassembles SYNC/payload/XOR-checksum byte frames into a validated word
// Ports:
//   clk  in  system clock (same domain as the uart core)
//   rst  in  asynchronous active-high reset
//   bus  slave modport of uart_frame_rx_if: read_done/read_data in; data, data_valid,
//        frame_err, busy, sta out
// Frame: SYNC_BYTE, WORD_BYTES payload bytes MSB first, then XOR of the payload bytes.
module uart_frame_rx #(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hAA,
  parameter int         TIMEOUT    = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  uart_frame_rx_if.slave bus
);
  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_rd_q;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [7:0]      r_chk, w_chk_nx;
  logic [DW-1:0]   r_sh, w_sh_nx;
  logic [TW-1:0]   r_timer, w_timer_nx;
  logic [DW-1:0]   r_data, w_data_nx;
  logic            r_data_valid, w_data_valid_nx;
  logic            r_frame_err, w_frame_err_nx;
  logic            r_busy, w_busy_nx;

  logic            w_ev;
  logic            w_expired;
  logic [TW-1:0]   w_timer_inc;

  // One byte per rising edge of read_done, so a held level counts once.
  assign w_ev      = bus.read_done & ~r_rd_q;
  assign w_expired = (r_timer == TW'(TIMEOUT - 1));
  // Saturate rather than wrap; expiry leaves the frame anyway.
  assign w_timer_inc = w_expired ? r_timer : r_timer + TW'(1);

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_chk_nx        = r_chk;
    w_sh_nx         = r_sh;
    w_timer_nx      = r_timer;
    w_data_nx       = r_data;
    w_data_valid_nx = 1'b0;
    w_frame_err_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_nx = '0;
        if (w_ev && (bus.read_data == SYNC_BYTE)) begin
          w_state_nx = S_PAYLOAD;
          w_cnt_nx   = '0;
          w_chk_nx   = 8'h00;
        end
      end

      S_PAYLOAD: begin
        // A byte on the expiry cycle still counts: ev is tested first.
        if (w_ev) begin
          w_sh_nx    = (r_sh << 8) | DW'(bus.read_data);
          w_chk_nx   = r_chk ^ bus.read_data;
          w_cnt_nx   = r_cnt + CW'(1);
          w_timer_nx = '0;
          if (r_cnt == CW'(WORD_BYTES - 1)) begin
            w_state_nx = S_CHECK;
          end
        end else if (w_expired) begin
          w_frame_err_nx = 1'b1;
          w_timer_nx     = '0;
          w_state_nx     = S_IDLE;
        end else begin
          w_timer_nx = w_timer_inc;
        end
      end

      S_CHECK: begin
        if (w_ev) begin
          w_timer_nx = '0;
          w_state_nx = S_IDLE;
          if (bus.read_data == r_chk) begin
            w_data_nx       = r_sh;
            w_data_valid_nx = 1'b1;
          end else begin
            w_frame_err_nx  = 1'b1;
          end
        end else if (w_expired) begin
          w_frame_err_nx = 1'b1;
          w_timer_nx     = '0;
          w_state_nx     = S_IDLE;
        end else begin
          w_timer_nx = w_timer_inc;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_timer_nx = '0;
      end
    endcase

    w_busy_nx = (w_state_nx == S_PAYLOAD) || (w_state_nx == S_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_q       <= 1'b0;
      r_cnt        <= '0;
      r_chk        <= 8'h00;
      r_sh         <= '0;
      r_timer      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_rd_q       <= bus.read_done;
      r_cnt        <= w_cnt_nx;
      r_chk        <= w_chk_nx;
      r_sh         <= w_sh_nx;
      r_timer      <= w_timer_nx;
      r_data       <= w_data_nx;
      r_data_valid <= w_data_valid_nx;
      r_frame_err  <= w_frame_err_nx;
      r_busy       <= w_busy_nx;
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;
  assign bus.sta        = {2'b00, r_state};
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx
module tb_uart_frame_rx;
  localparam int WB      = 4;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst;

  uart_frame_rx_if #(.WORD_BYTES(WB)) bus ();

  uart_frame_rx #(
    .WORD_BYTES (WB),
    .SYNC_BYTE  (8'hAA),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          err_cyc = -1;
  int          ev_cyc  = 0;
  logic [31:0] exp_data = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Strobe monitor: every data_valid / frame_err must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.data_valid || bus.frame_err)) begin
      exp_t e;
      check_eq("strobe_exclusive", {63'd0, bus.data_valid & bus.frame_err}, 64'd0);
      check_eq("strobe_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("strobe_kind_err", {63'd0, bus.frame_err}, {63'd0, e.err});
        check_eq("strobe_data", {32'd0, bus.data}, {32'd0, e.data});
      end
      if (bus.frame_err) err_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    bus.read_data = b;
    bus.read_done = 1'b1;
    ev_cyc = cyc + 1;
    repeat (hold) @(negedge clk);
    bus.read_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic err, input logic [31:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [7:0] ck, input int hold);
    logic [7:0] x;
    x = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    if (x == ck) begin
      exp_data = w;
      push_exp(1'b0, w);
    end else begin
      push_exp(1'b1, exp_data);
    end
    send_byte(8'hAA, hold);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], hold);
    send_byte(ck, hold);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.read_done = 1'b0;
    bus.read_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_data", {32'd0, bus.data}, 64'd0);
    check_eq("rst_dv", {63'd0, bus.data_valid}, 64'd0);
    check_eq("rst_fe", {63'd0, bus.frame_err}, 64'd0);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_sta", {60'd0, bus.sta}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: good frame
    send_frame(32'h12345678, 8'h08, 1);
    wait_drain("c1_drain", 20);
    check_eq("c1_data", {32'd0, bus.data}, 64'h12345678);
    check_eq("c1_sta", {60'd0, bus.sta}, 64'd0);

    // 2: bad checksum, data must hold
    send_frame(32'h12345678, 8'h09, 1);
    wait_drain("c2_drain", 20);
    check_eq("c2_data_held", {32'd0, bus.data}, 64'h12345678);

    // 3: garbage ignored, SYNC inside payload is data
    send_byte(8'h55, 1);
    check_eq("c3_sta_55", {60'd0, bus.sta}, 64'd0);
    send_byte(8'h00, 1);
    check_eq("c3_sta_00", {60'd0, bus.sta}, 64'd0);
    send_byte(8'hFF, 1);
    check_eq("c3_sta_ff", {60'd0, bus.sta}, 64'd0);
    send_frame(32'hAA000001, 8'hAB, 1);
    wait_drain("c3_drain", 20);
    check_eq("c3_data", {32'd0, bus.data}, 64'hAA000001);

    // 4: timeout after AA 12
    push_exp(1'b1, exp_data);
    send_byte(8'hAA, 1);
    check_eq("c4_sta_payload", {60'd0, bus.sta}, 64'd1);
    check_eq("c4_busy", {63'd0, bus.busy}, 64'd1);
    send_byte(8'h12, 1);
    err_cyc = -1;
    begin
      int e0;
      e0 = ev_cyc;
      wait_drain("c4_drain", TIMEOUT + 20);
      check_eq("c4_timeout_delay", 64'(err_cyc - e0), 64'(TIMEOUT));
    end
    check_eq("c4_sta_idle", {60'd0, bus.sta}, 64'd0);
    check_eq("c4_data_held", {32'd0, bus.data}, 64'hAA000001);
    send_frame(32'h12345678, 8'h08, 1);
    wait_drain("c4_recover_drain", 20);
    check_eq("c4_recover_data", {32'd0, bus.data}, 64'h12345678);

    // 4b: byte landing on the expiry cycle is accepted
    exp_data = 32'h12345678;
    push_exp(1'b0, 32'h12345678);
    send_byte(8'hAA, 1);
    send_byte(8'h12, 1);
    repeat (TIMEOUT - 2) @(negedge clk);
    check_eq("c4b_sta_before", {60'd0, bus.sta}, 64'd1);
    send_byte(8'h34, 1);
    check_eq("c4b_sta_after", {60'd0, bus.sta}, 64'd1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    send_byte(8'h08, 1);
    wait_drain("c4b_drain", 20);

    // 5: level held 20 cycles per byte
    send_frame(32'hA5C3_0F01, 8'hA5 ^ 8'hC3 ^ 8'h0F ^ 8'h01, 20);
    wait_drain("c5a_drain", 30);
    check_eq("c5a_data", {32'd0, bus.data}, 64'hA5C30F01);
    send_frame(32'h12345678, 8'h08, 20);
    wait_drain("c5_drain", 30);
    check_eq("c5_data", {32'd0, bus.data}, 64'h12345678);

    // 6: async reset mid-frame
    send_byte(8'hAA, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("c6_rst_data", {32'd0, bus.data}, 64'd0);
    check_eq("c6_rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("c6_rst_sta", {60'd0, bus.sta}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_data = 32'h0;
    @(negedge clk);
    send_frame(32'h12345678, 8'h08, 1);
    wait_drain("c6_drain", 20);
    check_eq("c6_data", {32'd0, bus.data}, 64'h12345678);

    repeat (TIMEOUT + 5) @(negedge clk);
    check_eq("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
